accel_responder_stub: RTL

// - Accelerator-side end of the CVA6->Ara request/response interface: stands in for Ara so dispatch

---
 rtl/accel_responder_stub_pkg.sv | 13 +
 rtl/accel_responder_stub_if.sv | 26 ++
 rtl/accel_stub_fifo.sv | 77 +++++++
 rtl/accel_responder_stub.sv | 97 +++++++++
 4 files changed

// File: rtl/accel_responder_stub_pkg.sv
// Shared types for the Ara-side request/response stub.
// Entry layout and the vector opcode that marks a request as valid.
package ara_pkg;

  localparam logic [6:0] OPCODE_VECTOR = 7'h57;

  typedef struct packed {
    logic [31:0] insn;
    logic [63:0] rs1;
    logic [63:0] rs2;
  } accel_stub_entry_t;

endpackage

// File: rtl/accel_responder_stub_if.sv
// CVA6->Ara request/response bundle.
// master = requester (CVA6 side), slave = responder (Ara side).
interface accel_responder_stub_if;

  logic        req_valid;
  logic        req_ready;
  logic [31:0] insn;
  logic [63:0] rs1;
  logic [63:0] rs2;
  logic        resp_valid;
  logic        resp_ready;
  logic [63:0] result;
  logic        error;
  logic [31:0] insn_echo;

  modport master (
    output req_valid, insn, rs1, rs2, resp_ready,
    input  req_ready, resp_valid, result, error, insn_echo
  );

  modport slave (
    input  req_valid, insn, rs1, rs2, resp_ready,
    output req_ready, resp_valid, result, error, insn_echo
  );

endinterface

// File: rtl/accel_stub_fifo.sv
// In-order pending-request buffer with a per-slot saturating age.
// Payload storage has no reset; pointers, count and ages do.
module accel_stub_fifo
  import ara_pkg::*;
#(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned LATENCY = 3,
  parameter int unsigned PW      = $clog2(DEPTH),
  parameter int unsigned AW      = $clog2(LATENCY + 1)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              push_i,
  input  accel_stub_entry_t entry_i,
  input  logic              pop_i,
  output logic              full_o,
  output logic              empty_o,
  output accel_stub_entry_t head_o,
  output logic [AW-1:0]     head_age_o
);

  accel_stub_entry_t mem_q [DEPTH];

  logic [AW-1:0] age_q [DEPTH];
  logic [AW-1:0] age_d [DEPTH];
  logic [PW-1:0] wptr_q, wptr_d;
  logic [PW-1:0] rptr_q, rptr_d;
  logic [PW:0]   cnt_q, cnt_d;

  assign full_o     = (cnt_q == (PW+1)'(DEPTH));
  assign empty_o    = (cnt_q == '0);
  assign head_o     = mem_q[rptr_q];
  assign head_age_o = age_q[rptr_q];

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    for (int i = 0; i < DEPTH; i++) begin
      age_d[i] = age_q[i];
      if (age_q[i] != AW'(LATENCY)) age_d[i] = age_q[i] + AW'(1);
    end
    if (push_i) begin
      age_d[wptr_q] = AW'(1);
      wptr_d        = wptr_q + PW'(1);
    end
    if (pop_i) rptr_d = rptr_q + PW'(1);
    unique case ({push_i, pop_i})
      2'b10:   cnt_d = cnt_q + (PW+1)'(1);
      2'b01:   cnt_d = cnt_q - (PW+1)'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
      for (int i = 0; i < DEPTH; i++) age_q[i] <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
      for (int i = 0; i < DEPTH; i++) age_q[i] <= age_d[i];
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_i) mem_q[wptr_q] <= entry_i;
  end

  a_cnt_bound: assert property (
    @(posedge clk_i) disable iff (!rst_ni) cnt_q <= (PW+1)'(DEPTH)
  );

endmodule

// File: rtl/accel_responder_stub.sv
// Ara stand-in: buffers requests, answers each after LATENCY cycles in order.
// Result is rs1+rs2; error flags a non-vector opcode.
module accel_responder_stub
  import ara_pkg::*;
#(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned LATENCY = 3,
  parameter int unsigned CNT_W   = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  logic [31:0]      insn_i,
  input  logic [63:0]      rs1_i,
  input  logic [63:0]      rs2_i,
  output logic             resp_valid_o,
  input  logic             resp_ready_i,
  output logic [63:0]      result_o,
  output logic             error_o,
  output logic [31:0]      insn_o,
  output logic             idle_o,
  output logic [CNT_W-1:0] n_req_o,
  output logic [CNT_W-1:0] n_resp_o
);

  localparam int unsigned AW = $clog2(LATENCY + 1);

  logic              full, empty, push, pop;
  accel_stub_entry_t entry, head;
  logic [AW-1:0]     head_age;
  logic [CNT_W-1:0]  n_req_q, n_req_d;
  logic [CNT_W-1:0]  n_resp_q, n_resp_d;

  assign entry = '{insn: insn_i, rs1: rs1_i, rs2: rs2_i};

  // No bypass: a full buffer refuses even when the head pops this cycle.
  assign req_ready_o  = ~full;
  assign push         = req_valid_i & ~full;
  assign resp_valid_o = ~empty & (head_age == AW'(LATENCY));
  assign pop          = resp_valid_o & resp_ready_i;
  assign idle_o       = empty;
  assign n_req_o      = n_req_q;
  assign n_resp_o     = n_resp_q;

  accel_stub_fifo #(
    .DEPTH   (DEPTH),
    .LATENCY (LATENCY)
  ) u_fifo (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .push_i     (push),
    .entry_i    (entry),
    .pop_i      (pop),
    .full_o     (full),
    .empty_o    (empty),
    .head_o     (head),
    .head_age_o (head_age)
  );

  always_comb begin
    result_o = '0;
    error_o  = 1'b0;
    insn_o   = '0;
    if (resp_valid_o) begin
      result_o = head.rs1 + head.rs2;
      error_o  = (head.insn[6:0] != OPCODE_VECTOR);
      insn_o   = head.insn;
    end
  end

  always_comb begin
    n_req_d  = n_req_q;
    n_resp_d = n_resp_q;
    if (push) n_req_d  = n_req_q + CNT_W'(1);
    if (pop)  n_resp_d = n_resp_q + CNT_W'(1);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      n_req_q  <= '0;
      n_resp_q <= '0;
    end else begin
      n_req_q  <= n_req_d;
      n_resp_q <= n_resp_d;
    end
  end

  a_latency: assert property (@(posedge clk_i) LATENCY >= 1);

  a_resp_hold: assert property (
    @(posedge clk_i) disable iff (!rst_ni)
    resp_valid_o && !resp_ready_i |=>
      resp_valid_o && $stable(result_o) && $stable(insn_o)
  );

endmodule
